// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the program counter, issues
//               word-aligned requests to instruction memory (one outstanding
//               at most), buffers responses with their PCs in a small
//               prefetch FIFO and presents {instruction, pc} downstream.
//               A redirect flushes all buffered and in-flight work.
// Ports       : clk            - rising-edge clock
//               reset          - asynchronous, active-low reset
//               imem_req_*     - request channel (valid/ready, word address)
//               imem_rsp_*     - response channel (one per accepted request)
//               redirect_*     - branch/jump restart address
//               inst_*         - FIFO head presented to the datapath
//               busy           - request outstanding or FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              INS_W      = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [PC_W-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [INS_W-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [INS_W-1:0] inst_data,
  output logic [PC_W-1:0]  inst_pc,
  output logic             busy
);

  localparam int                 c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w      = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(FIFO_DEPTH);
  localparam logic [PC_W-1:0]    c_pc_step    = PC_W'(4);
  localparam logic [PC_W-1:0]    c_align_mask = ~PC_W'(3);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // may issue a request
    ST_WAIT  = 2'd1,  // live request outstanding
    ST_DRAIN = 2'd2   // stale request outstanding, response is discarded
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    w_fetch_pc_nxt;
  logic [PC_W-1:0]    r_req_pc;
  logic               r_req_valid;
  logic               w_req_valid_nxt;
  logic [INS_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PC_W-1:0]    r_fifo_pc   [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_redirect_pc;

  assign w_redirect_pc = redirect_pc & c_align_mask;

  // r_req_valid is only ever set when the next state is ST_REQ, so it alone
  // qualifies the request handshake.
  assign w_accept = r_req_valid && imem_req_ready;

  // A redirect voids both the response push and the consumer pop.
  assign w_push = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop  = (r_count != '0) && inst_ready && !redirect_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      ST_REQ: begin
        if (w_accept) begin
          w_state_nxt    = ST_WAIT;
          w_fetch_pc_nxt = r_fetch_pc + c_pc_step;  // wraps modulo 2^PC_W
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) w_state_nxt = ST_REQ;
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_REQ;
    endcase

    // Redirect overrides the address. A request accepted this cycle, or a
    // live request still waiting, becomes stale and must be drained. A
    // response arriving in this same cycle closes the transaction (ST_WAIT
    // drops it via w_push; ST_DRAIN discards it as usual), so the state
    // computed above already returns to ST_REQ in those cases.
    if (redirect_valid) begin
      w_fetch_pc_nxt = w_redirect_pc;
      if ((r_state == ST_REQ) && w_accept) begin
        w_state_nxt = ST_DRAIN;
      end else if ((r_state == ST_WAIT) && !imem_rsp_valid) begin
        w_state_nxt = ST_DRAIN;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  // A request is only offered when the FIFO has room for its response, so
  // a push can never overflow.
  assign w_req_valid_nxt = (w_state_nxt == ST_REQ) && (w_count_nxt < c_depth);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_REQ;
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_count     <= w_count_nxt;
      if (w_accept) begin
        r_req_pc <= r_fetch_pc;
      end
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_fifo_data[r_wr_ptr] <= imem_rsp_data;
          r_fifo_pc[r_wr_ptr]   <= r_req_pc;
          r_wr_ptr              <= r_wr_ptr + c_ptr_w'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
      end
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = (r_count != '0);
  assign inst_data      = r_fifo_data[r_rd_ptr];
  assign inst_pc        = r_fifo_pc[r_rd_ptr];
  assign busy           = (r_state != ST_REQ) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. Stimulus pushes expected
//               request addresses and expected output PCs into queues; a
//               monitor pops and compares on every handshake. A memory model
//               answers each accepted request after a programmable latency
//               with address-tagged data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int PC_W  = 8;
  localparam int INS_W = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_rsp_valid;
  logic [INS_W-1:0] imem_rsp_data;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             inst_valid;
  logic             inst_ready;
  logic [INS_W-1:0] inst_data;
  logic [PC_W-1:0]  inst_pc;
  logic             busy;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W       (PC_W),
    .INS_W      (INS_W),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (8'h00)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
  );

  int              n_vec   = 0;
  int              n_err   = 0;
  int              mem_lat = 1;
  int              cyc     = 0;
  logic [PC_W-1:0] req_q[$];
  logic [PC_W-1:0] out_q[$];
  int              acc_cyc[$];

  function automatic logic [INS_W-1:0] tag(input logic [PC_W-1:0] a);
    return {16'hC0DE, 8'h5A, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Handshakes are judged at the falling edge: inputs change only just after
  // a rising edge, so what is seen here is what the next rising edge sees.
  task automatic run_monitor();
    logic [PC_W-1:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (imem_req_valid && imem_req_ready) begin
          acc_cyc.push_back(cyc);
          if (req_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_req: got addr 0x%0h, expected no request", imem_req_addr);
          end else begin
            e = req_q.pop_front();
            check("req_addr", 32'(imem_req_addr), 32'(e));
          end
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (out_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out: got pc 0x%0h, expected no output", inst_pc);
          end else begin
            e = out_q.pop_front();
            check("out_pc", 32'(inst_pc), 32'(e));
            check("out_data", inst_data, tag(e));
          end
        end
      end
    end
  endtask

  task automatic run_memory();
    int              cnt = 0;
    bit              acc;
    logic [PC_W-1:0] a;
    logic [PC_W-1:0] m_addr = '0;
    forever begin
      @(negedge clk);
      acc = reset && imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (acc) begin
        cnt    = mem_lat;
        m_addr = a;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = tag(m_addr);
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int left, input string name);
    for (int i = 0; i < 60 && req_q.size() > left; i++) tick(1);
    check(name, 32'(req_q.size()), 32'(left));
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 60 && out_q.size() != 0; i++) tick(1);
    check(name, 32'(out_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag_s);
    check({tag_s, "_req_valid"},  32'(imem_req_valid), 32'd0);
    check({tag_s, "_req_addr"},   32'(imem_req_addr),  32'h00);
    check({tag_s, "_inst_valid"}, 32'(inst_valid),     32'd0);
    check({tag_s, "_inst_data"},  inst_data,           32'd0);
    check({tag_s, "_inst_pc"},    32'(inst_pc),        32'd0);
    check({tag_s, "_busy"},       32'(busy),           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    fork
      run_monitor();
      run_memory();
    join_none

    tick(3);
    check_idle_outputs("reset");

    // 1: sequential fetch from RESET_PC, one request every other cycle
    req_q = '{8'h00, 8'h04, 8'h08};
    out_q = '{8'h00, 8'h04, 8'h08};
    acc_cyc.delete();
    reset = 1'b1;
    wait_req(0, "t1_req_timeout");
    imem_req_ready = 1'b0;
    wait_out("t1_out_timeout");
    check("t1_accept_count", 32'(acc_cyc.size()), 32'd3);
    if (acc_cyc.size() == 3) begin
      check("t1_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      check("t1_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end

    // 2: consumer stalled, FIFO fills to depth and requests stop
    inst_ready = 1'b0;
    req_q.push_back(8'h0C);
    req_q.push_back(8'h10);
    imem_req_ready = 1'b1;
    wait_req(0, "t2_fill_timeout");
    tick(6);
    check("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_full_inst_valid", 32'(inst_valid), 32'd1);
    check("t2_full_head_pc", 32'(inst_pc), 32'h0C);
    check("t2_full_busy", 32'(busy), 32'd1);
    req_q.push_back(8'h14);
    out_q = '{8'h0C, 8'h10, 8'h14};
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    wait_req(0, "t2_refill_timeout");
    imem_req_ready = 1'b0;
    tick(3);
    check("t2_refull_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_refull_head_pc", 32'(inst_pc), 32'h10);
    inst_ready = 1'b1;
    wait_out("t2_out_timeout");

    // 3: redirect to 0x43 while waiting on a slow (3-cycle) response
    mem_lat = 3;
    req_q.push_back(8'h18);
    req_q.push_back(8'h40);
    out_q.push_back(8'h40);
    imem_req_ready = 1'b1;
    wait_req(1, "t3_first_timeout");
    redirect_valid = 1'b1;
    redirect_pc    = 8'h43;
    tick(1);
    redirect_valid = 1'b0;
    check("t3_drain_inst_valid", 32'(inst_valid), 32'd0);
    check("t3_drain_busy", 32'(busy), 32'd1);
    check("t3_drain_req_valid", 32'(imem_req_valid), 32'd0);
    wait_req(0, "t3_req_timeout");
    imem_req_ready = 1'b0;
    wait_out("t3_out_timeout");
    mem_lat = 1;

    // 4: redirect in the same cycle as the accept of 0x10
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    tick(1);
    redirect_valid = 1'b0;
    check("t4_pending_valid", 32'(imem_req_valid), 32'd1);
    check("t4_pending_addr", 32'(imem_req_addr), 32'h10);
    req_q.push_back(8'h10);
    req_q.push_back(8'h80);
    out_q.push_back(8'h80);
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    tick(1);
    redirect_valid = 1'b0;
    check("t4_drain_busy", 32'(busy), 32'd1);
    check("t4_drain_req_valid", 32'(imem_req_valid), 32'd0);
    wait_req(0, "t4_req_timeout");
    imem_req_ready = 1'b0;
    wait_out("t4_out_timeout");

    // 5: redirect in the same cycle as the response in WAIT
    req_q.push_back(8'h84);
    req_q.push_back(8'h20);
    out_q.push_back(8'h20);
    imem_req_ready = 1'b1;
    wait_req(1, "t5_first_timeout");
    redirect_valid = 1'b1;
    redirect_pc    = 8'h21;
    tick(1);
    redirect_valid = 1'b0;
    check("t5_next_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_next_req_addr", 32'(imem_req_addr), 32'h20);
    check("t5_no_push", 32'(inst_valid), 32'd0);
    wait_req(0, "t5_req_timeout");
    imem_req_ready = 1'b0;
    wait_out("t5_out_timeout");

    // 6: PC wrap 0xFC -> 0x00, then reset in the middle of WAIT
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFC;
    tick(1);
    redirect_valid = 1'b0;
    req_q.push_back(8'hFC);
    req_q.push_back(8'h00);
    out_q.push_back(8'hFC);
    out_q.push_back(8'h00);
    imem_req_ready = 1'b1;
    wait_req(0, "t6_wrap_timeout");
    imem_req_ready = 1'b0;
    wait_out("t6_wrap_out_timeout");
    req_q.push_back(8'h04);
    imem_req_ready = 1'b1;
    wait_req(0, "t6_mid_timeout");
    check("t6_wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    tick(2);
    req_q.push_back(8'h00);
    out_q.push_back(8'h00);
    reset = 1'b1;
    wait_req(0, "t6_refetch_timeout");
    imem_req_ready = 1'b0;
    wait_out("t6_refetch_out_timeout");

    tick(3);
    check("end_busy", 32'(busy), 32'd0);
    check("end_req_q_empty", 32'(req_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the single-cycle datapath. It owns the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel. It buffers returned instructions with their PCs in a small prefetch FIFO. A valid/ready output presents {instruction, pc} to the datapath, and a redirect input flushes all in-flight and buffered work.

Parameters:
PC_W, 8, program counter / instruction address width in bits
INS_W, 32, instruction width
FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2
RESET_PC, 0, fetch address after reset; word aligned

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  instruction memory accepts request
imem_req_addr  output  PC_W  fetch address; bits [1:0] always 0
imem_rsp_valid  input  1  response valid; exactly one per accepted request, in order, at least 1 cycle after accept
imem_rsp_data  input  INS_W  returned instruction
redirect_valid  input  1  branch/jump: flush and restart
redirect_pc  input  PC_W  new fetch address; bits [1:0] ignored (forced 0)
inst_valid  output  1  FIFO head valid
inst_ready  input  1  datapath consumes head
inst_data  output  INS_W  head instruction
inst_pc  output  PC_W  PC of head instruction
busy  output  1  request outstanding or FIFO non-empty

Behaviour:
- Reset (reset=0, async): state=REQ, fetch_pc=RESET_PC, FIFO empty, outstanding=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, busy=0.
- At most one request outstanding. Handshakes complete on a clk edge with valid&&ready. imem_req_valid and imem_req_addr stay stable until accepted, unless a redirect occurs.
- FSM states:
  - REQ: imem_req_valid=1 only if fifo_count < FIFO_DEPTH (space is reserved for the response). imem_req_addr=fetch_pc. On accept: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go to WAIT.
  - WAIT: on imem_rsp_valid, push {imem_rsp_data, req_pc} and go to REQ.
  - DRAIN: a stale response is pending. On imem_rsp_valid, discard it and go to REQ. A new request is issued no earlier than the cycle after the stale response.
- PC arithmetic is modulo 2^PC_W: 0xFC+4 wraps to 0x00. No flag is raised.
- Redirect (redirect_valid=1) takes priority over all other events in the same cycle:
  - FIFO cleared; inst_valid=0 next cycle.
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - REQ with no accept this cycle: stay in REQ.
  - REQ with accept this same cycle: the request is stale; go to DRAIN.
  - WAIT without response: go to DRAIN.
  - WAIT with response this cycle: drop the response; go to REQ.
  - DRAIN: stay in DRAIN (response still pending); a second redirect only updates fetch_pc.
  - A pop coinciding with a redirect is void. The datapath must ignore inst_* in a redirect cycle.
- FIFO:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pop when empty has no effect.
  - Push never overflows because of the space reservation in REQ.
  - inst_* are driven from the head entry: response at edge N means inst_valid=1 after edge N (zero added latency beyond the register write).
  - inst_data and inst_pc are held stable while inst_valid && !inst_ready.
- Back-to-back throughput: with 1-cycle memory latency, one instruction every 2 cycles. Peak rate is not a goal.
- busy = (state != REQ) || (fifo_count != 0).
- Reset asserted mid-transaction aborts everything. A response arriving after reset deassertion while state=REQ is ignored (no outstanding request is recorded).

Test Plan:
1. Reset release, RESET_PC=0x00, memory ready=1 with 1-cycle latency returning addr-tagged data, inst_ready=1 -> requests 0x00,0x04,0x08 on alternate cycles; outputs pc 0x00/0x04/0x08 in order with matching data.
2. inst_ready=0, FIFO_DEPTH=2 -> exactly 2 entries fill; imem_req_valid stays 0. Raise inst_ready for one cycle -> exactly one new request issued; no entry lost or duplicated.
3. Redirect to 0x43 while in WAIT, response 3 cycles later -> stale response dropped; next request addr=0x40; first output pc=0x40; FIFO empty in between.
4. Redirect in the same cycle as a request accept (addr 0x10), redirect_pc=0x80 -> DRAIN; the 0x10 response is discarded; next request=0x80.
5. Redirect in the same cycle as a response in WAIT -> that response is not pushed; a request to the new PC is issued the next cycle.
6. fetch_pc=0xFC -> request 0xFC then 0x00; outputs in wrap order. Assert reset mid-WAIT -> all outputs 0 immediately; refetch from RESET_PC after release.
